// File: rtl/pll_reset_seq.sv
// Lock-qualified reset sequencer: synchronises pll_locked, waits for a stable lock, then
// releases domain resets in staggered order; lock loss or a software request re-sequences.
module pll_reset_seq #(
  parameter int NUM_DOMAINS      = 3,
  parameter int STABLE_CYCLES    = 1024,
  parameter int STAGGER_CYCLES   = 16,
  parameter int SYNC_STAGES      = 2,
  parameter int LOSS_COUNT_WIDTH = 8
) (
  input  logic                        clock_in,
  input  logic                        reset_n,
  input  logic                        pll_locked,
  input  logic                        sw_reset_req,
  output logic [NUM_DOMAINS-1:0]      domain_reset_n,
  output logic                        all_ready,
  output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count,
  output logic [1:0]                  state
);

  localparam int STW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
  localparam int SGW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [STW-1:0] STAB_LAST = STW'(STABLE_CYCLES - 1);
  localparam logic [SGW-1:0] STAG_LAST = SGW'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]      sync_q;
  logic                        locked_s;
  state_t                      state_q;
  logic [NUM_DOMAINS-1:0]      dom_q;
  logic                        rdy_q;
  logic [LOSS_COUNT_WIDTH-1:0] loss_q;
  logic [STW-1:0]              stab_q;
  logic [SGW-1:0]              stag_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      dom_q   <= '0;
      rdy_q   <= 1'b0;
      loss_q  <= '0;
      stab_q  <= '0;
      stag_q  <= '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= STABILIZE;
            stab_q  <= '0;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
          end else if (sw_reset_req) begin
            stab_q <= '0;
          end else if (stab_q == STAB_LAST) begin
            state_q <= RELEASE;
            dom_q   <= NUM_DOMAINS'(1);
            stag_q  <= '0;
          end else begin
            stab_q <= stab_q + 1'b1;
          end
        end
        RELEASE, RUN: begin
          // Lock loss takes priority over a simultaneous software request.
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            dom_q   <= '0;
            rdy_q   <= 1'b0;
            if (~&loss_q) loss_q <= loss_q + 1'b1;
          end else if (sw_reset_req) begin
            state_q <= STABILIZE;
            stab_q  <= '0;
            dom_q   <= '0;
            rdy_q   <= 1'b0;
          end else if (state_q == RELEASE) begin
            if (&dom_q) begin
              state_q <= RUN;
              rdy_q   <= 1'b1;
            end else if (stag_q == STAG_LAST) begin
              // Thermometer shift keeps released bits monotone, bit 0 first.
              dom_q  <= (dom_q << 1) | NUM_DOMAINS'(1);
              stag_q <= '0;
            end else begin
              stag_q <= stag_q + 1'b1;
            end
          end
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  assign domain_reset_n  = dom_q;
  assign all_ready       = rdy_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: bring-up timing, lock glitches and loss, software
// re-sequence, loss-count saturation and asynchronous reset.
module tb_pll_reset_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_req;
  logic [2:0] dom;
  logic       rdy;
  logic [1:0] loss;
  logic [1:0] st;

  int n_pass;
  int n_fail;
  int n_total;

  pll_reset_seq #(
    .NUM_DOMAINS     (3),
    .STABLE_CYCLES   (8),
    .STAGGER_CYCLES  (4),
    .SYNC_STAGES     (2),
    .LOSS_COUNT_WIDTH(2)
  ) dut (
    .clock_in       (clk),
    .reset_n        (rst_n),
    .pll_locked     (pll_locked),
    .sw_reset_req   (sw_req),
    .domain_reset_n (dom),
    .all_ready      (rdy),
    .lock_loss_count(loss),
    .state          (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered right after pll_locked rises at a negedge with a clear synchroniser in WAIT_LOCK.
  task automatic bringup();
    step(2);  chk("sync_latency_state", 32'(st), 0);
    step(1);  chk("stabilize_entry", 32'(st), 1);
    step(7);  chk("pre_bit0", 32'(dom), 0);
    step(1);  chk("bit0_rise", 32'(dom), 1);
              chk("release_state", 32'(st), 2);
    step(3);  chk("pre_bit1", 32'(dom), 1);
    step(1);  chk("bit1_rise", 32'(dom), 3);
    step(3);  chk("pre_bit2", 32'(dom), 3);
    step(1);  chk("bit2_rise", 32'(dom), 7);
              chk("ready_before_run", 32'(rdy), 0);
    step(1);  chk("all_ready_rise", 32'(rdy), 1);
              chk("run_state", 32'(st), 3);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0; pll_locked = 1'b0; sw_req = 1'b0;
    #12;
    chk("reset_state", 32'(st), 0);
    chk("reset_dom", 32'(dom), 0);
    chk("reset_ready", 32'(rdy), 0);
    chk("reset_loss", 32'(loss), 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("idle_unlocked", 32'(st), 0);

    // Lock glitch during STABILIZE
    pll_locked = 1'b1;
    step(7);
    chk("glitch_in_stab", 32'(st), 1);
    pll_locked = 1'b0;
    step(2);  chk("glitch_not_seen_yet", 32'(st), 1);
    step(1);  chk("glitch_to_wait", 32'(st), 0);
              chk("glitch_no_release", 32'(dom), 0);
              chk("glitch_no_loss", 32'(loss), 0);
    pll_locked = 1'b1;
    bringup();

    // Lock loss in RUN
    pll_locked = 1'b0;
    step(2);  chk("loss_pending_ready", 32'(rdy), 1);
    step(1);  chk("loss_dom", 32'(dom), 0);
              chk("loss_ready", 32'(rdy), 0);
              chk("loss_state", 32'(st), 0);
              chk("loss_count1", 32'(loss), 1);
    step(2);
    pll_locked = 1'b1;
    bringup();

    // Software request in RUN, then again in RELEASE after bit0
    sw_req = 1'b1; step(1); sw_req = 1'b0;
    chk("sw_run_state", 32'(st), 1);
    chk("sw_run_dom", 32'(dom), 0);
    chk("sw_run_ready", 32'(rdy), 0);
    step(7);  chk("sw_pre_bit0", 32'(dom), 0);
    step(1);  chk("sw_bit0", 32'(dom), 1);
    sw_req = 1'b1; step(1); sw_req = 1'b0;
    chk("sw_rel_dom", 32'(dom), 0);
    chk("sw_rel_state", 32'(st), 1);
    chk("sw_rel_loss", 32'(loss), 1);
    step(7);  chk("resq_pre_bit0", 32'(dom), 0);
    step(1);  chk("resq_bit0", 32'(dom), 1);
    step(4);  chk("resq_bit1", 32'(dom), 3);
    step(4);  chk("resq_bit2", 32'(dom), 7);
    step(1);  chk("resq_ready", 32'(rdy), 1);

    // Simultaneous lock loss and software request
    pll_locked = 1'b0;
    step(2);
    sw_req = 1'b1; step(1); sw_req = 1'b0;
    chk("both_state", 32'(st), 0);
    chk("both_loss", 32'(loss), 2);
    chk("both_dom", 32'(dom), 0);

    // Three more losses from RELEASE: count saturates at 3
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b1;
      step(11); chk("sat_bit0", 32'(dom), 1);
      pll_locked = 1'b0;
      step(3);  chk("sat_state", 32'(st), 0);
                chk("sat_loss", 32'(loss), 3);
    end

    // Asynchronous reset mid-RELEASE
    pll_locked = 1'b1;
    step(15);
    chk("pre_reset_dom", 32'(dom), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dom", 32'(dom), 0);
    chk("arst_state", 32'(st), 0);
    chk("arst_loss", 32'(loss), 0);
    step(2);
    rst_n = 1'b1;
    bringup();
    chk("final_loss", 32'(loss), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
